ram_lsu: RTL

Load/store sequencer that acts as the initiator for the 1024-byte, byte-wide, registered-read data RAM. It accepts one CPU load or store per transaction (byte, halfword or word, little-endian) and breaks it into byte accesses on the RAM write and read ports. For loads it collects the returned bytes into a sign- or zero-extended 32-bit result. It sits between the execute stage and the data RAM.

---
 rtl/ram_lsu.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ram_lsu.sv
// ram_lsu: load/store sequencer driving a byte-wide, registered-read data RAM.
// One CPU load or store (byte/half/word, little-endian) is split into
// consecutive byte accesses; load bytes are gathered and sign/zero-extended.
module ram_lsu #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  input  logic [1:0]    i_size,
  input  logic          i_unsigned,
  input  logic [31:0]   i_wdata,
  output logic          o_ready,
  output logic          o_done,
  output logic          o_err,
  output logic [31:0]   o_rdata,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [7:0]    o_wdata,
  output logic [AW-1:0] o_raddr,
  input  logic [7:0]    i_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, RESP} state_t;

  state_t        r_state;
  logic [AW-1:0] r_base;
  logic [2:0]    r_nbytes;
  logic [2:0]    r_cnt;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [23:0]   r_wshift;
  logic [23:0]   r_rshift;

  logic          w_bad;
  logic [2:0]    w_nbytes;
  logic [AW-1:0] w_next_addr;
  logic [31:0]   w_rfull;
  logic          w_fill;
  logic [31:0]   w_rext;

  // A request is rejected when its size is illegal or it is not naturally aligned.
  assign w_bad = (i_size == 2'd3) ||
                 ((i_size == 2'd1) && i_addr[0]) ||
                 ((i_size == 2'd2) && (i_addr[1:0] != 2'b00));

  assign w_nbytes    = (i_size == 2'd0) ? 3'd1 : (i_size == 2'd1) ? 3'd2 : 3'd4;
  assign w_next_addr = r_base + AW'(r_cnt);

  // Load bytes shift in from the top, so the final byte completes the value here.
  assign w_rfull = {i_rdata, r_rshift};
  assign w_fill  = ~r_unsigned & w_rfull[31];

  // Right-justify the gathered bytes and fill the upper bits from the top byte.
  always_comb begin
    w_rext = w_rfull;
    case (r_size)
      2'd0:    w_rext = {{24{w_fill}}, w_rfull[31:24]};
      2'd1:    w_rext = {{16{w_fill}}, w_rfull[31:16]};
      default: w_rext = w_rfull;
    endcase
  end

  // Transaction sequencer: accept, walk the bytes, then pulse the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_nbytes   <= 3'd0;
      r_cnt      <= 3'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_wshift   <= '0;
      r_rshift   <= '0;
      o_ready    <= 1'b1;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_rdata    <= '0;
      o_we       <= 1'b0;
      o_waddr    <= '0;
      o_wdata    <= '0;
      o_raddr    <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        IDLE, RESP: begin
          r_state <= IDLE;
          o_ready <= 1'b1;
          if (i_req) begin
            r_base     <= i_addr;
            r_size     <= i_size;
            r_unsigned <= i_unsigned;
            r_nbytes   <= w_nbytes;
            r_cnt      <= 3'd1;
            if (w_bad) begin
              r_state <= RESP;
              o_done  <= 1'b1;
              o_err   <= 1'b1;
            end else if (i_wr) begin
              r_state  <= WR;
              o_ready  <= 1'b0;
              o_we     <= 1'b1;
              o_waddr  <= i_addr;
              o_wdata  <= i_wdata[7:0];
              r_wshift <= i_wdata[31:8];
            end else begin
              r_state <= RD;
              o_ready <= 1'b0;
              o_raddr <= i_addr;
            end
          end
        end
        WR: begin
          if (r_cnt == r_nbytes) begin
            r_state <= RESP;
            o_ready <= 1'b1;
            o_done  <= 1'b1;
            o_we    <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
          end else begin
            o_waddr  <= w_next_addr;
            o_wdata  <= r_wshift[7:0];
            r_wshift <= {8'h00, r_wshift[23:8]};
            r_cnt    <= r_cnt + 3'd1;
          end
        end
        RD: begin
          if (r_cnt != 3'd1) begin
            r_rshift <= {i_rdata, r_rshift[23:8]};
          end
          if (r_cnt == r_nbytes) begin
            r_state <= DRAIN;
            o_raddr <= '0;
          end else begin
            o_raddr <= w_next_addr;
            r_cnt   <= r_cnt + 3'd1;
          end
        end
        DRAIN: begin
          r_state <= RESP;
          o_ready <= 1'b1;
          o_done  <= 1'b1;
          o_rdata <= w_rext;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
